ma_pipeline: RTL and testbench

//  Memory-access stage: consumer end of the EX/MA register. Takes ALU result, store data and controls from EX/MA.

---
 rtl/ma_pipeline_if.sv | 21 ++
 rtl/ma_pipeline.sv | 189 ++++++++++++++++++
 tb/tb_ma_pipeline.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ma_pipeline_if.sv
// Data-memory request/response bundle between the MA stage
// and the memory.
interface ma_pipeline_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/ma_pipeline.sv
// Memory-access stage: one data-memory transaction per load/store,
// load/store formatting, writeback select, MA/WB and WB2 registers.
module ma_pipeline #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          RegWEn_in,
    input  logic          MemRW_in,
    input  logic [1:0]    WBSel_in,
    input  logic [2:0]    funct3_in,
    input  logic [31:0]   ALU_Result_in,
    input  logic [31:0]   DataB_in,
    input  logic [31:0]   pcPlus4_in,
    input  logic [4:0]    AddrD_in,
    ma_pipeline_if.master mem,
    output logic          stall_out,
    output logic          mem_err,
    output logic          misalign_err,
    output logic          RegWEn_out,
    output logic [4:0]    AddrD_out,
    output logic [31:0]   WB_Result_out,
    output logic          RegWEn2_out,
    output logic [4:0]    AddrD2_out,
    output logic [31:0]   WB_Result2_out
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  count;
    logic [31:0] load_buf;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic        mem_op;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        misalign;
    logic        go;
    logic        reg_we;
    logic [1:0]  lane;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] st_data;
    logic [3:0]  st_strb;
    logic [31:0] wb_value;

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_wstrb = wstrb_q;

    assign lane   = ALU_Result_in[1:0];
    assign mem_op = MemRW_in | (WBSel_in == 2'b00);

    // funct3 100/101 only mean LBU/LHU for loads; stores treat them as SW
    assign is_byte = (funct3_in == 3'b000)
                   | (!MemRW_in && funct3_in == 3'b100);
    assign is_half = (funct3_in == 3'b001)
                   | (!MemRW_in && funct3_in == 3'b101);
    assign is_word = !is_byte && !is_half;

    assign misalign = mem_op
                    & ((is_half & lane[0])
                    |  (is_word & (lane != 2'b00)));

    assign go        = (state == IDLE) & mem_op & ~misalign;
    assign stall_out = go | (state == BUSY);
    assign reg_we    = RegWEn_in & (AddrD_in != 5'd0);

    always_comb begin
        st_data = DataB_in;
        st_strb = 4'b1111;
        unique case (1'b1)
            is_byte: begin
                st_data = {4{DataB_in[7:0]}};
                st_strb = 4'b0001 << lane;
            end
            is_half: begin
                st_data = {2{DataB_in[15:0]}};
                st_strb = lane[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    assign ld_byte = load_buf[{lane, 3'b000} +: 8];
    assign ld_half = lane[1] ? load_buf[31:16] : load_buf[15:0];

    always_comb begin
        ld_data = load_buf;
        unique case (1'b1)
            is_byte: ld_data = funct3_in[2]
                             ? {24'h0, ld_byte}
                             : {{24{ld_byte[7]}}, ld_byte};
            is_half: ld_data = funct3_in[2]
                             ? {16'h0, ld_half}
                             : {{16{ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

    always_comb begin
        wb_value = 32'h0;
        unique case (WBSel_in)
            2'b00:   wb_value = ld_data;
            2'b01:   wb_value = ALU_Result_in;
            2'b10:   wb_value = pcPlus4_in;
            default: wb_value = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            count          <= 8'd0;
            load_buf       <= 32'h0;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= 32'h0;
            wdata_q        <= 32'h0;
            wstrb_q        <= 4'h0;
            mem_err        <= 1'b0;
            misalign_err   <= 1'b0;
            RegWEn_out     <= 1'b0;
            AddrD_out      <= 5'd0;
            WB_Result_out  <= 32'h0;
            RegWEn2_out    <= 1'b0;
            AddrD2_out     <= 5'd0;
            WB_Result2_out <= 32'h0;
        end else begin
            mem_err        <= 1'b0;
            misalign_err   <= 1'b0;
            RegWEn2_out    <= RegWEn_out;
            AddrD2_out     <= AddrD_out;
            WB_Result2_out <= WB_Result_out;
            RegWEn_out     <= 1'b0;
            AddrD_out      <= 5'd0;
            WB_Result_out  <= 32'h0;
            unique case (state)
                IDLE: begin
                    if (go) begin
                        state   <= BUSY;
                        count   <= 8'd0;
                        req_q   <= 1'b1;
                        we_q    <= MemRW_in;
                        addr_q  <= {ALU_Result_in[31:2], 2'b00};
                        wdata_q <= st_data;
                        wstrb_q <= MemRW_in ? st_strb : 4'h0;
                    end else begin
                        RegWEn_out    <= reg_we & ~misalign;
                        AddrD_out     <= AddrD_in;
                        WB_Result_out <= wb_value;
                        misalign_err  <= misalign;
                    end
                end
                BUSY: begin
                    if (mem.mem_ready) begin
                        load_buf <= mem.mem_rdata;
                        req_q    <= 1'b0;
                        state    <= DONE;
                    end else if (count == LAST) begin
                        load_buf <= 32'h0;
                        req_q    <= 1'b0;
                        mem_err  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                DONE: begin
                    RegWEn_out    <= reg_we;
                    AddrD_out     <= AddrD_in;
                    WB_Result_out <= wb_value;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ma_pipeline.sv
// Randomized bench for ma_pipeline against a transaction-level
// model of the memory-access stage.
module tb_ma_pipeline;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        RegWEn_in;
    logic        MemRW_in;
    logic [1:0]  WBSel_in;
    logic [2:0]  funct3_in;
    logic [31:0] ALU_Result_in;
    logic [31:0] DataB_in;
    logic [31:0] pcPlus4_in;
    logic [4:0]  AddrD_in;
    logic        stall_out;
    logic        mem_err;
    logic        misalign_err;
    logic        RegWEn_out;
    logic [4:0]  AddrD_out;
    logic [31:0] WB_Result_out;
    logic        RegWEn2_out;
    logic [4:0]  AddrD2_out;
    logic [31:0] WB_Result2_out;

    int n_vec = 0;
    int n_bad = 0;

    ma_pipeline_if bus();

    ma_pipeline #(.TIMEOUT_CYCLES(T)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .RegWEn_in      (RegWEn_in),
        .MemRW_in       (MemRW_in),
        .WBSel_in       (WBSel_in),
        .funct3_in      (funct3_in),
        .ALU_Result_in  (ALU_Result_in),
        .DataB_in       (DataB_in),
        .pcPlus4_in     (pcPlus4_in),
        .AddrD_in       (AddrD_in),
        .mem            (bus.master),
        .stall_out      (stall_out),
        .mem_err        (mem_err),
        .misalign_err   (misalign_err),
        .RegWEn_out     (RegWEn_out),
        .AddrD_out      (AddrD_out),
        .WB_Result_out  (WB_Result_out),
        .RegWEn2_out    (RegWEn2_out),
        .AddrD2_out     (AddrD2_out),
        .WB_Result2_out (WB_Result2_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic nop_inputs();
        RegWEn_in     = 1'b0;
        MemRW_in      = 1'b0;
        WBSel_in      = 2'b11;
        funct3_in     = 3'b000;
        ALU_Result_in = 32'h0;
        DataB_in      = 32'h0;
        pcPlus4_in    = 32'h0;
        AddrD_in      = 5'd0;
    endtask

    // access size in bytes
    function automatic int size_of(input logic mrw,
                                   input logic [2:0] f3);
        if (f3 == 3'b000 || (!mrw && f3 == 3'b100)) return 1;
        if (f3 == 3'b001 || (!mrw && f3 == 3'b101)) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] load_fmt(input logic [2:0] f3,
                                             input logic [31:0] a,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(d >> (8 * int'(a[1:0])));
        h = 16'(d >> (16 * int'(a[1])));
        case (f3)
            3'b000:  return 32'($signed(b));
            3'b001:  return 32'($signed(h));
            3'b100:  return 32'(b);
            3'b101:  return 32'(h);
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] st_strb(input int sz,
                                           input logic [31:0] a);
        return 4'(((1 << sz) - 1) << int'(a[1:0]));
    endfunction

    function automatic logic [31:0] st_data(input int sz,
                                            input logic [31:0] d);
        if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] wb_sel(input logic [1:0] s,
                                           input logic [31:0] alu,
                                           input logic [31:0] pc4,
                                           input logic [31:0] ld);
        case (s)
            2'b00:   return ld;
            2'b01:   return alu;
            2'b10:   return pc4;
            default: return 32'h0;
        endcase
    endfunction

    // Apply one instruction; w = BUSY cycle on which ready comes.
    task automatic run(input logic rwe, input logic mrw,
                       input logic [1:0] wbsel,
                       input logic [2:0] f3,
                       input logic [31:0] alu,
                       input logic [31:0] db,
                       input logic [31:0] pc4,
                       input logic [31:0] rdat,
                       input logic [4:0] rd,
                       input int w);
        int          sz;
        logic        mo;
        logic        mis;
        logic        exp_we;
        logic [31:0] exp_res;
        logic [31:0] buf_v;
        sz  = size_of(mrw, f3);
        mo  = mrw || (wbsel == 2'b00);
        mis = mo && (int'(alu[1:0]) % sz != 0);
        RegWEn_in     = rwe;
        MemRW_in      = mrw;
        WBSel_in      = wbsel;
        funct3_in     = f3;
        ALU_Result_in = alu;
        DataB_in      = db;
        pcPlus4_in    = pc4;
        AddrD_in      = rd;
        #1;
        check("stall_issue", 32'(stall_out), 32'(mo && !mis));
        if (!mo || mis) begin
            @(posedge clk);
            @(negedge clk);
            check("misalign_err", 32'(misalign_err), 32'(mis));
            check("req_none", 32'(bus.mem_req), 32'h0);
            exp_we  = rwe && (rd != 0) && !mis;
            exp_res = wb_sel(wbsel, alu, pc4, 32'h0);
            check("regwen", 32'(RegWEn_out), 32'(exp_we));
            if (!mis) begin
                check("rd", 32'(AddrD_out), 32'(rd));
                check("wb_result", WB_Result_out, exp_res);
            end
        end else begin
            @(posedge clk);
            for (int k = 0; k < T; k++) begin
                @(negedge clk);
                check("stall_busy", 32'(stall_out), 32'h1);
                check("req_busy", 32'(bus.mem_req), 32'h1);
                check("bubble", 32'(RegWEn_out), 32'h0);
                if (k == 0) begin
                    check("addr", bus.mem_addr,
                          {alu[31:2], 2'b00});
                    check("we", 32'(bus.mem_we), 32'(mrw));
                    check("wstrb", 32'(bus.mem_wstrb),
                          mrw ? 32'(st_strb(sz, alu)) : 32'h0);
                    if (mrw)
                        check("wdata", bus.mem_wdata,
                              st_data(sz, db));
                end
                if (k == w) begin
                    bus.mem_rdata = rdat;
                    bus.mem_ready = 1'b1;
                end
                @(posedge clk);
                if (k == w) break;
            end
            @(negedge clk);
            bus.mem_ready = 1'b0;
            bus.mem_rdata = $urandom;
            buf_v = (w < T) ? rdat : 32'h0;
            check("stall_done", 32'(stall_out), 32'h0);
            check("req_done", 32'(bus.mem_req), 32'h0);
            check("mem_err", 32'(mem_err), 32'(w >= T));
            @(posedge clk);
            @(negedge clk);
            exp_we  = rwe && (rd != 0);
            exp_res = wb_sel(wbsel, alu, pc4,
                             load_fmt(f3, alu, buf_v));
            check("regwen_mem", 32'(RegWEn_out), 32'(exp_we));
            check("rd_mem", 32'(AddrD_out), 32'(rd));
            check("wb_result_mem", WB_Result_out, exp_res);
            check("mem_err_pulse", 32'(mem_err), 32'h0);
        end
        nop_inputs();
        @(posedge clk);
        @(negedge clk);
        check("regwen2", 32'(RegWEn2_out), 32'(exp_we));
        if (!mis) begin
            check("rd2", 32'(AddrD2_out), 32'(rd));
            check("wb_result2", WB_Result2_out, exp_res);
        end
    endtask

    initial begin
        logic [31:0] alu;
        logic [1:0]  ws;
        logic        mrw;
        int          op;
        nop_inputs();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_req", 32'(bus.mem_req), 32'h0);
        check("rst_wstrb", 32'(bus.mem_wstrb), 32'h0);
        check("rst_regwen", 32'(RegWEn_out), 32'h0);
        check("rst_wb", WB_Result_out, 32'h0);
        check("rst_wb2", WB_Result2_out, 32'h0);
        check("rst_stall", 32'(stall_out), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        run(1, 0, 2'b01, 3'b000, 32'd12, 0, 32'h104, 0, 5'd3, 0);
        run(1, 0, 2'b00, 3'b000, 32'h102, 0, 32'h108,
            32'h0080_0000, 5'd5, 0);
        run(0, 1, 2'b01, 3'b001, 32'h206, 32'h1234_ABCD,
            32'h10C, 32'h0, 5'd0, 3);
        run(1, 0, 2'b00, 3'b010, 32'h101, 0, 32'h110,
            32'h0, 5'd6, 0);
        run(1, 0, 2'b00, 3'b010, 32'h300, 0, 32'h114,
            32'hDEAD_BEEF, 5'd7, 100);
        run(1, 0, 2'b01, 3'b000, 32'h55, 0, 32'h118, 0, 5'd0, 0);
        run(1, 0, 2'b00, 3'b101, 32'h402, 0, 32'h11C,
            32'h8001_1234, 5'd9, 1);
        run(1, 0, 2'b00, 3'b010, 32'h600, 0, 32'h120,
            32'hCAFE_F00D, 5'd10, T - 1);
        run(0, 1, 2'b10, 3'b000, 32'h703, 32'h0000_00A5,
            32'h124, 32'h0, 5'd11, 2);

        for (int i = 0; i < 300; i++) begin
            op  = $urandom_range(0, 2);
            alu = $urandom;
            if ($urandom_range(0, 1) == 1) alu[0] = 1'b0;
            if ($urandom_range(0, 1) == 1) alu[1] = 1'b0;
            mrw = (op == 2);
            ws  = (op == 1) ? 2'b00 : 2'($urandom_range(1, 3));
            run(1'($urandom), mrw, ws, 3'($urandom_range(0, 7)),
                alu, $urandom, $urandom, $urandom,
                5'($urandom_range(0, 31)), $urandom_range(0, 5));
        end

        RegWEn_in     = 1'b1;
        MemRW_in      = 1'b0;
        WBSel_in      = 2'b00;
        funct3_in     = 3'b010;
        ALU_Result_in = 32'h500;
        AddrD_in      = 5'd4;
        @(posedge clk);
        @(negedge clk);
        check("busy_before_rst", 32'(bus.mem_req), 32'h1);
        reset_n = 1'b0;
        nop_inputs();
        #1;
        check("arst_req", 32'(bus.mem_req), 32'h0);
        check("arst_stall", 32'(stall_out), 32'h0);
        check("arst_regwen", 32'(RegWEn_out), 32'h0);
        check("arst_wb", WB_Result_out, 32'h0);
        check("arst_addr", bus.mem_addr, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_req", 32'(bus.mem_req), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule
